multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle MIPS controller: sequences the shared ALU, memory port and register file over per-instruction steps.
//  Replaces the single-cycle ControlPath decode and drives the multicycle datapath's mux selects and write strobes.
//  Stalls on a memory ready handshake and halts permanently on a memory timeout.
//  Counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles per memory state before halting (1..255)
//  CNT_W        32  width of InstrCount
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  instrWord    in   32     instruction register contents; opcode = instrWord[31:26]
//  MemReady     in   1      memory completes the current access this cycle
//  Zero         in   1      ALU zero flag (beq compare)
//  PCWrite      out  1      unconditional PC write
//  PCWriteCond  out  1      PC write if Zero
//  IorD         out  1      0=PC, 1=ALUOut as memory address
//  MemRead      out  1      memory read request
//  MemWrite     out  1      memory write request
//  MemToReg     out  1      1=MDR, 0=ALUOut to register write data
//  IRWrite      out  1      load instruction register
//  PCSource     out  2      00=ALU, 01=ALUOut, 10=jump target
//  ALUOp        out  2      00=add, 01=sub, 10=funct
//  ALUSrcA      out  1      0=PC, 1=rs
//  ALUSrcB      out  2      00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
//  RegWrite     out  1      register file write
//  RegDest      out  1      1=rd, 0=rt
//  Illegal      out  1      one-cycle pulse: unknown opcode decoded
//  Halted       out  1      sticky: memory timeout; cleared only by reset
//  InstrCount   out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=FETCH, waitCnt=0, InstrCount=0, Halted=0; every output forced 0 while reset is high.
//  Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010; all others are illegal.
//  FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
//    IRWrite and PCWrite assert only in the cycle MemReady=1; that cycle moves to DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
//    lw/sw->MEMADDR, R->EXEC, beq->BRANCH, j->JUMP, illegal->FETCH with Illegal=1 for that cycle.
//  MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD for lw, MEMWR for sw.
//  MEMRD: MemRead=1, IorD=1; advances to MEMWB on MemReady.
//  MEMWB: RegWrite=1, MemToReg=1, RegDest=0 -> FETCH; retires.
//  MEMWR: MemWrite=1, IorD=1; on MemReady -> FETCH; retires.
//  EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
//  RWB: RegWrite=1, RegDest=1, MemToReg=0 -> FETCH; retires.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH; retires.
//  JUMP: PCWrite=1, PCSource=10 -> FETCH; retires.
//  Outputs not listed for a state are 0.
//  Retire: InstrCount+1 on the final cycle of each legal instruction; illegal opcodes do not retire.
//  Latency with MemReady=1 throughout: R 4, lw 5, sw 4, beq 3, j 3, illegal 2 cycles.
//  Wait: in FETCH/MEMRD/MEMWR, waitCnt increments each cycle MemReady=0 and clears on state exit.
//    When waitCnt==MEM_TIMEOUT with MemReady=0, go to HALT.
//    MemReady arriving in the same cycle wins: no halt.
//  HALT: all strobes 0, Halted=1, stays until reset; InstrCount frozen.
//  Reset asserted mid-instruction aborts at once, with no retire and no partial strobes.
//  instrWord is sampled only in DECODE; changes at any other time are ignored.
// TESTING
//  T1: instrWord=32'h01555555, MemReady=1 -> FETCH,DECODE,EXEC,RWB; RegWrite&RegDest in RWB; InstrCount=1.
//  T2: lw 32'h8EAAAAAA, MemReady=0 for 3 cycles in MEMRD -> MemRead,IorD held 3 extra cycles; MEMWB RegWrite,MemToReg=1.
//  T3: sw 32'hAC000000 -> MEMWR MemWrite=1,IorD=1, RegWrite never 1; beq Zero=1 -> PCWriteCond=1,ALUOp=01.
//  T4: 32'hFFFFFFFF, 32'h94000000, 32'hD4000000 -> Illegal pulses once each in DECODE, back to FETCH, InstrCount unchanged.
//  T5: MemReady=0 in FETCH for MEM_TIMEOUT cycles -> HALT, Halted=1 sticky; MemReady at cycle 15 -> no halt.
//  T6: reset asserted in MEMRD -> outputs 0 asynchronously; after release, FETCH with InstrCount=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS controller. Sequences the shared ALU, memory port and
// register file over per-instruction steps. Stalls on MemReady, halts for
// good on a memory timeout, and counts retired instructions.
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instrWord,
    input  logic             MemReady,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             IRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDest,
    output logic             Illegal,
    output logic             Halted,
    output logic [CNT_W-1:0] InstrCount
);

    localparam int unsigned WAIT_W = 8;

    localparam logic [5:0] OpR   = 6'b000000;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpSw  = 6'b101011;
    localparam logic [5:0] OpBeq = 6'b000100;
    localparam logic [5:0] OpJ   = 6'b000010;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr,
        StExec, StRwb, StBranch, StJump, StHalt
    } state_t;

    // Control word that depends only on the state; registered alongside it.
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic [1:0] pcsource;
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
        logic       regdest;
        logic       halted;
    } ctl_t;

    state_t              state_q, state_d;
    ctl_t                ctl_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    count_q;
    logic                is_lw_q;
    logic                retire;
    logic                timeout;
    logic                legal;
    logic [5:0]          opcode;
    logic                unused_inputs;

    assign opcode  = instrWord[31:26];
    assign legal   = (opcode == OpR) || (opcode == OpLw) || (opcode == OpSw) ||
                     (opcode == OpBeq) || (opcode == OpJ);
    assign timeout = (wait_q == WAIT_W'(MEM_TIMEOUT));

    // Zero is consumed by the datapath together with PCWriteCond.
    assign unused_inputs = Zero ^ (^instrWord[25:0]);

    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
            end
            StDecode:  c.alusrcb = 2'b11;
            StMemAddr: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            StMemRd: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            StMemWb: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            StMemWr: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            StExec: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            StRwb: begin
                c.regwrite = 1'b1;
                c.regdest  = 1'b1;
            end
            StBranch: begin
                c.alusrca     = 1'b1;
                c.aluop       = 2'b01;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
            end
            StJump: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b10;
            end
            StHalt:  c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Next state, memory wait counter and retire strobe.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        retire  = 1'b0;
        case (state_q)
            StFetch, StMemRd, StMemWr: begin
                if (MemReady) begin
                    if (state_q == StFetch) begin
                        state_d = StDecode;
                    end else if (state_q == StMemRd) begin
                        state_d = StMemWb;
                    end else begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpR:        state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAddr: state_d = is_lw_q ? StMemRd : StMemWr;
            StExec:    state_d = StRwb;
            StMemWb, StRwb, StBranch, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // State, registered control word, wait counter and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            ctl_q   <= state_ctl(StFetch);
            wait_q  <= '0;
            count_q <= '0;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= state_ctl(state_d);
            wait_q  <= wait_d;
            if (retire) begin
                count_q <= count_q + 1'b1;
            end
            // Remember lw vs sw so MEMADDR ignores later instrWord changes.
            if (state_q == StDecode) begin
                is_lw_q <= (opcode == OpLw);
            end
        end
    end

    // The control register holds FETCH values during reset, so gate every strobe.
    always_comb begin
        PCWrite     = ~reset & (ctl_q.pcwrite | ((state_q == StFetch) & MemReady));
        PCWriteCond = ~reset & ctl_q.pcwritecond;
        IorD        = ~reset & ctl_q.iord;
        MemRead     = ~reset & ctl_q.memread;
        MemWrite    = ~reset & ctl_q.memwrite;
        MemToReg    = ~reset & ctl_q.memtoreg;
        IRWrite     = ~reset & (state_q == StFetch) & MemReady;
        PCSource    = reset ? 2'b00 : ctl_q.pcsource;
        ALUOp       = reset ? 2'b00 : ctl_q.aluop;
        ALUSrcA     = ~reset & ctl_q.alusrca;
        ALUSrcB     = reset ? 2'b00 : ctl_q.alusrcb;
        RegWrite    = ~reset & ctl_q.regwrite;
        RegDest     = ~reset & ctl_q.regdest;
        Illegal     = ~reset & (state_q == StDecode) & ~legal;
        Halted      = ~reset & ctl_q.halted;
        InstrCount  = count_q;
    end

endmodule
